// File: rtl/otter_csr_int_unit.sv
// Machine-mode CSR file and external-interrupt front end for the multicycle OTTER core.
//
// Implements mstatus (MIE/MPIE only), mtvec, mepc and mcause. Synchronises the
// asynchronous interrupt line, detects its rising edge and keeps a pending flag
// for the control FSM. Consumes the FSM's take/clear/write/mret strobes.
//
// Ports:
//   CSR_CLK        clock
//   CSR_RESET_N    synchronous reset, active low
//   CSR_INT_IN     external interrupt line (asynchronous, level)
//   CSR_ADDR       CSR address (IR[31:20])
//   CSR_WDATA      CSRRW write data
//   CSR_WRITE      CSRRW write strobe
//   CSR_INT_TAKEN  FSM is in its interrupt state this cycle
//   CSR_INT_CLR    FSM end-of-instruction clear of the pending interrupt
//   CSR_MRET       mret executing this cycle
//   CSR_PC         PC of next instruction, saved to mepc on entry
//   CSR_RDATA      combinational read of CSR_ADDR (pre-write value)
//   CSR_INT        new interrupt edge accepted this cycle
//   CSR_PREV_INT   latched pending interrupt, masked by MIE
//   CSR_MTVEC      trap vector
//   CSR_MEPC       return address
//   CSR_MIE        mstatus.MIE
module otter_csr_int_unit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
  input  logic        CSR_CLK,
  input  logic        CSR_RESET_N,
  input  logic        CSR_INT_IN,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WDATA,
  input  logic        CSR_WRITE,
  input  logic        CSR_INT_TAKEN,
  input  logic        CSR_INT_CLR,
  input  logic        CSR_MRET,
  input  logic [31:0] CSR_PC,
  output logic [31:0] CSR_RDATA,
  output logic        CSR_INT,
  output logic        CSR_PREV_INT,
  output logic [31:0] CSR_MTVEC,
  output logic [31:0] CSR_MEPC,
  output logic        CSR_MIE
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   delay_q, delay_d;
  logic                   pend_q, pend_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic [31:0]            mtvec_q, mtvec_d;
  logic [31:0]            mepc_q, mepc_d;
  logic [31:0]            mcause_q, mcause_d;

  logic int_edge;
  logic mret_eff;
  logic unused_pc_bits;

  assign unused_pc_bits = ^CSR_PC[1:0];

  // Edge is high for the one cycle where the synchronised level is new.
  assign int_edge     = sync_q[SYNC_STAGES-1] & ~delay_q;
  assign CSR_INT      = int_edge & mie_q;
  assign CSR_PREV_INT = pend_q & mie_q;
  assign CSR_MTVEC    = mtvec_q;
  assign CSR_MEPC     = mepc_q;
  assign CSR_MIE      = mie_q;

  // Interrupt entry shadows mret on the shared mstatus fields.
  assign mret_eff = CSR_MRET & ~CSR_INT_TAKEN;

  always_comb begin
    CSR_RDATA = 32'h0;
    case (CSR_ADDR)
      AddrMstatus: CSR_RDATA = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
      AddrMtvec:   CSR_RDATA = mtvec_q;
      AddrMepc:    CSR_RDATA = mepc_q;
      AddrMcause:  CSR_RDATA = mcause_q;
      default:     CSR_RDATA = 32'h0;
    endcase
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], CSR_INT_IN};
    delay_d  = sync_q[SYNC_STAGES-1];
    pend_d   = pend_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;

    // Set wins over clear; an edge masked by MIE=0 is never latched.
    if (CSR_INT) begin
      pend_d = 1'b1;
    end else if (CSR_INT_CLR || CSR_INT_TAKEN) begin
      pend_d = 1'b0;
    end

    // Lowest priority first; later assignments override per field.
    if (CSR_WRITE) begin
      case (CSR_ADDR)
        AddrMstatus: begin
          mie_d  = CSR_WDATA[3];
          mpie_d = CSR_WDATA[7];
        end
        AddrMtvec:  mtvec_d  = {CSR_WDATA[31:2], 2'b00};
        AddrMepc:   mepc_d   = {CSR_WDATA[31:2], 2'b00};
        AddrMcause: mcause_d = CSR_WDATA;
        default: ;
      endcase
    end

    if (mret_eff) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (CSR_INT_TAKEN) begin
      mepc_d   = {CSR_PC[31:2], 2'b00};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = MCAUSE_EXT;
    end
  end

  always_ff @(posedge CSR_CLK) begin
    if (!CSR_RESET_N) begin
      sync_q   <= '0;
      delay_q  <= 1'b0;
      pend_q   <= 1'b0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
    end else begin
      sync_q   <= sync_d;
      delay_q  <= delay_d;
      pend_q   <= pend_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

endmodule

// File: tb/tb_otter_csr_int_unit.sv
// Directed self-checking bench for otter_csr_int_unit (SYNC_STAGES=2).
module tb_otter_csr_int_unit;

  logic        clk;
  logic        rst_n;
  logic        int_in;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        taken;
  logic        clr;
  logic        mret;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        int_o;
  logic        prev_int;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;

  int errors = 0;
  int checks = 0;

  otter_csr_int_unit #(
    .SYNC_STAGES(2),
    .MTVEC_RESET(32'h0000_0000),
    .MCAUSE_EXT (32'h8000_000B)
  ) dut (
    .CSR_CLK      (clk),
    .CSR_RESET_N  (rst_n),
    .CSR_INT_IN   (int_in),
    .CSR_ADDR     (addr),
    .CSR_WDATA    (wdata),
    .CSR_WRITE    (wr),
    .CSR_INT_TAKEN(taken),
    .CSR_INT_CLR  (clr),
    .CSR_MRET     (mret),
    .CSR_PC       (pc),
    .CSR_RDATA    (rdata),
    .CSR_INT      (int_o),
    .CSR_PREV_INT (prev_int),
    .CSR_MTVEC    (mtvec),
    .CSR_MEPC     (mepc),
    .CSR_MIE      (mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    addr = 12'h300;
    #1;
    checks++; if (mtvec !== 32'h0) begin errors++;
      $display("FAIL reset_mtvec got=%h exp=%h", mtvec, 32'h0); end
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL reset_mstatus got=%h exp=%h", rdata, 32'h0); end
    checks++; if (int_o !== 1'b0 || prev_int !== 1'b0) begin errors++;
      $display("FAIL reset_int got=%b%b exp=00", int_o, prev_int); end
    checks++; if (mepc !== 32'h0 || mie !== 1'b0) begin errors++;
      $display("FAIL reset_mepc_mie got=%h/%b exp=0/0", mepc, mie); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_csrrw();
    csr_write(12'h305, 32'h0000_0103);
    checks++; if (mtvec !== 32'h0000_0100) begin errors++;
      $display("FAIL csrrw_mtvec got=%h exp=%h", mtvec, 32'h0000_0100); end
    addr = 12'h305; #1;
    checks++; if (rdata !== 32'h0000_0100) begin errors++;
      $display("FAIL csrrw_rd_mtvec got=%h exp=%h", rdata, 32'h0000_0100); end
    csr_write(12'h123, 32'hFFFF_FFFF);
    addr = 12'h123; #1;
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL csrrw_unmapped got=%h exp=%h", rdata, 32'h0); end
    // Read shows the old value during the write cycle.
    addr = 12'h342; wdata = 32'hDEAD_BEEF; wr = 1'b1; #1;
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL csrrw_old_val got=%h exp=%h", rdata, 32'h0); end
    tick(); wr = 1'b0; #1;
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL csrrw_mcause got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    csr_write(12'h341, 32'h0000_1237);
    checks++; if (mepc !== 32'h0000_1234) begin errors++;
      $display("FAIL csrrw_mepc got=%h exp=%h", mepc, 32'h0000_1234); end
    csr_write(12'h300, 32'hFFFF_FFFF);
    addr = 12'h300; #1;
    checks++; if (rdata !== 32'h0000_0088 || mie !== 1'b1) begin errors++;
      $display("FAIL csrrw_mstatus got=%h/%b exp=%h/1", rdata, mie, 32'h88); end
  endtask

  task automatic test_int_entry();
    int_in = 1'b1;
    tick();
    checks++; if (int_o !== 1'b0) begin errors++;
      $display("FAIL entry_int_early got=%b exp=0", int_o); end
    tick();
    checks++; if (int_o !== 1'b1 || prev_int !== 1'b0) begin errors++;
      $display("FAIL entry_int_pulse got=%b%b exp=10", int_o, prev_int); end
    tick();
    checks++; if (int_o !== 1'b0 || prev_int !== 1'b1) begin errors++;
      $display("FAIL entry_pending got=%b%b exp=01", int_o, prev_int); end
    tick();
    checks++; if (int_o !== 1'b0 || prev_int !== 1'b1) begin errors++;
      $display("FAIL entry_hold got=%b%b exp=01", int_o, prev_int); end
    taken = 1'b1; pc = 32'h0000_004B;
    tick();
    taken = 1'b0;
    addr = 12'h300; #1;
    checks++; if (mepc !== 32'h48 || mie !== 1'b0 || rdata !== 32'h80) begin errors++;
      $display("FAIL entry_state got=%h/%b/%h exp=48/0/80", mepc, mie, rdata); end
    addr = 12'h342; #1;
    checks++; if (rdata !== 32'h8000_000B || prev_int !== 1'b0) begin errors++;
      $display("FAIL entry_mcause got=%h/%b exp=8000000b/0", rdata, prev_int); end
    int_in = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    addr = 12'h300; #1;
    checks++; if (rdata !== 32'h88 || mie !== 1'b1 || prev_int !== 1'b0) begin errors++;
      $display("FAIL mret_restore got=%h/%b/%b exp=88/1/0", rdata, mie, prev_int); end
    mret = 1'b1; taken = 1'b1; pc = 32'h0000_0100;
    tick();
    mret = 1'b0; taken = 1'b0; #1;
    checks++; if (mie !== 1'b0 || rdata !== 32'h80 || mepc !== 32'h100) begin errors++;
      $display("FAIL mret_vs_entry got=%b/%h/%h exp=0/80/100", mie, rdata, mepc); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic test_masked();
    csr_write(12'h300, 32'h0);
    int_in = 1'b1;
    tick();
    int_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (int_o !== 1'b0) begin errors++;
        $display("FAIL masked_int[%0d] got=%b exp=0", i, int_o); end
    end
    csr_write(12'h300, 32'h8);
    tick();
    checks++; if (int_o !== 1'b0 || prev_int !== 1'b0 || mie !== 1'b1) begin errors++;
      $display("FAIL masked_after got=%b%b%b exp=001", int_o, prev_int, mie); end
  endtask

  task automatic test_race();
    int_in = 1'b1;
    tick();
    tick();
    checks++; if (int_o !== 1'b1) begin errors++;
      $display("FAIL race_edge got=%b exp=1", int_o); end
    clr = 1'b1;
    tick();
    clr = 1'b0; #1;
    checks++; if (prev_int !== 1'b1) begin errors++;
      $display("FAIL race_set_wins got=%b exp=1", prev_int); end
    clr = 1'b1;
    tick();
    clr = 1'b0; #1;
    checks++; if (prev_int !== 1'b0) begin errors++;
      $display("FAIL race_clear got=%b exp=0", prev_int); end
    int_in = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_priority();
    // Write to mtvec is untouched by entry and completes alongside it.
    addr = 12'h305; wdata = 32'h0000_0200; wr = 1'b1; taken = 1'b1; pc = 32'h300;
    tick();
    wr = 1'b0; taken = 1'b0; #1;
    checks++; if (mtvec !== 32'h200 || mepc !== 32'h300) begin errors++;
      $display("FAIL prio_mtvec got=%h/%h exp=200/300", mtvec, mepc); end
    addr = 12'h341; wdata = 32'h444; wr = 1'b1; taken = 1'b1; pc = 32'h500;
    tick();
    wr = 1'b0; taken = 1'b0; #1;
    checks++; if (mepc !== 32'h500) begin errors++;
      $display("FAIL prio_mepc got=%h exp=%h", mepc, 32'h500); end
    // State now MIE=0, MPIE=0; mret beats a write of MIE=1/MPIE=0.
    addr = 12'h300; wdata = 32'h8; wr = 1'b1; mret = 1'b1;
    tick();
    wr = 1'b0; mret = 1'b0; #1;
    checks++; if (rdata !== 32'h80) begin errors++;
      $display("FAIL prio_mret_write got=%h exp=%h", rdata, 32'h80); end
  endtask

  task automatic test_reset_mid();
    csr_write(12'h300, 32'h8);
    int_in = 1'b1;
    tick(); tick(); tick();
    checks++; if (prev_int !== 1'b1) begin errors++;
      $display("FAIL rstmid_pending got=%b exp=1", prev_int); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    checks++; if (prev_int !== 1'b0 || mie !== 1'b0 || mtvec !== 32'h0) begin errors++;
      $display("FAIL rstmid_cleared got=%b/%b/%h exp=0/0/0", prev_int, mie, mtvec); end
    tick(); tick(); tick();
    checks++; if (int_o !== 1'b0 || prev_int !== 1'b0) begin errors++;
      $display("FAIL rstmid_no_int got=%b%b exp=00", int_o, prev_int); end
    int_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; int_in = 1'b0; addr = '0; wdata = '0; wr = 1'b0;
    taken = 1'b0; clr = 1'b0; mret = 1'b0; pc = '0;
    test_reset();
    test_csrrw();
    test_int_entry();
    test_mret();
    test_masked();
    test_race();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
